inst_block_refill_cache: RTL and testbench

Responder side of the fetch unit's instruction-block interface. Fetch presents a block-aligned PC and samples a full instruction block plus a hit flag. On a miss, this block refills the addressed line from instruction memory one word per beat, then raises hit. It sits between fetch and the instruction memory model, replacing the fixed-latency cache.

---
 rtl/inst_block_refill_cache_if.sv | 30 +++
 rtl/inst_block_refill_cache.sv | 166 ++++++++++++++++
 tb/tb_inst_block_refill_cache.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_block_refill_cache_if.sv
// Fetch/instruction-memory bundle for inst_block_refill_cache.
// ICACHE_STATS_EN adds the hit/miss counter signals.
interface inst_block_refill_cache_if #(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 32,
    parameter int ADDR_W          = 32
) ();
    logic [ADDR_W-1:0]                    pc_in;
    logic [WORD_SIZE*WORDS_PER_BLOCK-1:0] block_out;
    logic                                 hit;
    logic                                 busy;
    logic                                 mem_req;
    logic [ADDR_W-1:0]                    mem_addr;
    logic [WORD_SIZE-1:0]                 mem_rdata;
    logic                                 mem_valid;
`ifdef ICACHE_STATS_EN
    logic [31:0]                          hit_count;
    logic [31:0]                          miss_count;

    modport slave  (input  pc_in, mem_rdata, mem_valid,
                    output block_out, hit, busy, mem_req, mem_addr, hit_count, miss_count);
    modport master (output pc_in, mem_rdata, mem_valid,
                    input  block_out, hit, busy, mem_req, mem_addr, hit_count, miss_count);
`else
    modport slave  (input  pc_in, mem_rdata, mem_valid,
                    output block_out, hit, busy, mem_req, mem_addr);
    modport master (output pc_in, mem_rdata, mem_valid,
                    input  block_out, hit, busy, mem_req, mem_addr);
`endif
endinterface

// File: rtl/inst_block_refill_cache.sv
// Direct-mapped instruction block cache with word-per-beat refill from memory.
// Optional ICACHE_STATS_EN adds saturating hit/miss counters.
module inst_block_refill_cache #(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 32,
    parameter int LINES           = 8,
    parameter int ADDR_W          = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    inst_block_refill_cache_if.slave  bus
);
    localparam int WORD_BYTES = WORD_SIZE / 8;
    localparam int OFF_W      = $clog2(WORD_BYTES * WORDS_PER_BLOCK);
    localparam int IDX_W      = $clog2(LINES);
    localparam int TAG_W      = ADDR_W - OFF_W - IDX_W;
    localparam int BEAT_W     = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        FILL_DONE = 2'd2
    } state_t;

    state_t                         state_r;
    logic [LINES-1:0]               valid_r;
    logic [LINES-1:0][TAG_W-1:0]    tag_r;
    logic [WORD_SIZE-1:0]           data_r [LINES][WORDS_PER_BLOCK];
    logic [BEAT_W-1:0]              beat_r;
    logic                           mem_req_r;
    logic [ADDR_W-1:0]              mem_addr_r;
    logic                           busy_r;

    logic [IDX_W-1:0]               index_s;
    logic [TAG_W-1:0]               tag_s;
    logic [IDX_W-1:0]               fill_index_s;
    logic [TAG_W-1:0]               fill_tag_s;
    logic                           hit_s;
    logic [WORD_SIZE*WORDS_PER_BLOCK-1:0] block_s;
    logic                           unused_s;

    assign index_s      = bus.pc_in[OFF_W +: IDX_W];
    assign tag_s        = bus.pc_in[ADDR_W-1 -: TAG_W];
    // mem_addr_r holds the line base plus beat offset, so its upper bits name the line being filled
    assign fill_index_s = mem_addr_r[OFF_W +: IDX_W];
    assign fill_tag_s   = mem_addr_r[ADDR_W-1 -: TAG_W];
    assign hit_s        = (state_r == IDLE) && valid_r[index_s] && (tag_r[index_s] == tag_s);
    assign unused_s     = ^bus.pc_in[OFF_W-1:0];

    // Zero-latency lookup: present the indexed line only on a hit
    always_comb begin
        block_s = '0;
        if (hit_s) begin
            for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
                block_s[(WORDS_PER_BLOCK-1-k)*WORD_SIZE +: WORD_SIZE] = data_r[index_s][k];
            end
        end else begin
            block_s = '0;
        end
    end

    assign bus.block_out = block_s;
    assign bus.hit       = hit_s;
    assign bus.busy      = busy_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_addr  = mem_addr_r;

    // Refill controller: miss detection, beat sequencing and line validation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            valid_r    <= '0;
            tag_r      <= '0;
            beat_r     <= '0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!hit_s) begin
                        valid_r[index_s] <= 1'b0;
                        beat_r           <= '0;
                        mem_req_r        <= 1'b1;
                        mem_addr_r       <= {bus.pc_in[ADDR_W-1:OFF_W], OFF_W'(0)};
                        busy_r           <= 1'b1;
                        state_r          <= REFILL;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REFILL: begin
                    if (bus.mem_valid) begin
                        if (beat_r == BEAT_W'(WORDS_PER_BLOCK-1)) begin
                            mem_req_r <= 1'b0;
                            state_r   <= FILL_DONE;
                        end else begin
                            beat_r     <= beat_r + BEAT_W'(1);
                            mem_addr_r <= mem_addr_r + ADDR_W'(WORD_BYTES);
                        end
                    end else begin
                        state_r <= REFILL;
                    end
                end
                FILL_DONE: begin
                    valid_r[fill_index_s] <= 1'b1;
                    tag_r[fill_index_s]   <= fill_tag_s;
                    beat_r                <= '0;
                    busy_r                <= 1'b0;
                    state_r               <= IDLE;
                end
                default: begin
                    mem_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // Line data capture; contents are only trusted once the valid bit is set
    always_ff @(posedge clk) begin
        if (state_r == REFILL && bus.mem_valid) begin
            data_r[fill_index_s][beat_r] <= bus.mem_rdata;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0]       hit_count_r;
    logic [31:0]       miss_count_r;
    logic [ADDR_W-1:0] prev_pc_r;
    logic              first_hit_r;

    assign bus.hit_count  = hit_count_r;
    assign bus.miss_count = miss_count_r;

    // Saturating counters; a hit counts once per new PC or first hit after reset/refill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
            prev_pc_r    <= '0;
            first_hit_r  <= 1'b1;
        end else begin
            prev_pc_r <= bus.pc_in;
            if (state_r == IDLE && !hit_s && miss_count_r != 32'hFFFF_FFFF) begin
                miss_count_r <= miss_count_r + 32'd1;
            end else begin
                miss_count_r <= miss_count_r;
            end
            if (hit_s && (bus.pc_in != prev_pc_r || first_hit_r)) begin
                if (hit_count_r != 32'hFFFF_FFFF) begin
                    hit_count_r <= hit_count_r + 32'd1;
                end else begin
                    hit_count_r <= hit_count_r;
                end
                first_hit_r <= 1'b0;
            end else if (state_r == FILL_DONE) begin
                first_hit_r <= 1'b1;
            end else begin
                first_hit_r <= first_hit_r;
            end
        end
    end
`endif
endmodule

// File: tb/tb_inst_block_refill_cache.sv
// Directed bench for inst_block_refill_cache: line-level cache model checked every cycle
// plus hand-computed expectations. Memory returns each word equal to its byte address.
module tb_inst_block_refill_cache;
    localparam int W     = 32;
    localparam int WPB   = 32;
    localparam int LINES = 8;
    localparam int AW    = 32;
    localparam int BW    = W * WPB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_block_refill_cache_if #(.WORD_SIZE(W), .WORDS_PER_BLOCK(WPB), .ADDR_W(AW)) bus ();

    inst_block_refill_cache #(.WORD_SIZE(W), .WORDS_PER_BLOCK(WPB), .LINES(LINES), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mem_rdata = bus.mem_addr;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int vmode = 1;
    int beats = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- line-level reference model ----------------
    logic           m_valid [LINES];
    logic [AW-1:0]  m_base  [LINES];
    int             m_left;
    bit             m_done;
    logic [AW-1:0]  m_fill;

    function automatic logic m_hit(input logic [AW-1:0] pc);
        return (m_left == 0) && !m_done && m_valid[pc[9:7]] && (m_base[pc[9:7]][31:10] == pc[31:10]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) m_valid[i] <= 1'b0;
            m_left <= 0;
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            if (bus.mem_valid) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_done <= 1'b1;
            end
        end else if (m_done) begin
            m_done               <= 1'b0;
            m_valid[m_fill[9:7]] <= 1'b1;
            m_base[m_fill[9:7]]  <= m_fill;
        end else if (!m_hit(bus.pc_in)) begin
            m_fill                  <= {bus.pc_in[31:7], 7'd0};
            m_left                  <= WPB;
            m_valid[bus.pc_in[9:7]] <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_valid) beats <= beats + 1;
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (!rst && chk_en) begin : cmp
            logic          eh;
            logic [AW-1:0] lb;
            logic [W-1:0]  aw, ew;
            eh = m_hit(bus.pc_in);
            check("hit", 64'(bus.hit), 64'(eh));
            check("busy", 64'(bus.busy), 64'((m_left > 0) || m_done));
            check("mem_req", 64'(bus.mem_req), 64'(m_left > 0));
            if (m_left > 0)
                check("mem_addr", 64'(bus.mem_addr), 64'(m_fill + 32'(4 * (WPB - m_left))));
            if (eh) begin
                lb = m_base[bus.pc_in[9:7]];
                aw = bus.block_out[BW-1 -: W];
                ew = lb;
                for (int k = WPB - 1; k >= 0; k--) begin
                    if (bus.block_out[BW-1-W*k -: W] !== lb + 32'(4 * k)) begin
                        aw = bus.block_out[BW-1-W*k -: W];
                        ew = lb + 32'(4 * k);
                    end
                end
                check("block_word", 64'(aw), 64'(ew));
            end else begin
                check("block_zero", 64'(|bus.block_out), 64'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
        bus.mem_valid = (vmode == 0) ? 1'b0 : ((cyc % vmode) == 0);
    endtask

    task automatic wait_hit(input string name, input int bound, output int busy_cycles);
        bit done;
        done = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < bound && !done; i++) begin
            step();
            #2;
            if (bus.hit) done = 1'b1;
            else if (bus.busy) busy_cycles++;
        end
        check(name, 64'(done), 64'd1);
    endtask

    task automatic wait_addr(input string name, input logic [AW-1:0] addr, input int bound);
        bit found;
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            step();
            #2;
            if (bus.mem_req && bus.mem_addr == addr) found = 1'b1;
        end
        check(name, 64'(found), 64'd1);
    endtask

    function automatic logic [W-1:0] top_word();
        return bus.block_out[BW-1 -: W];
    endfunction

    function automatic logic [W-1:0] low_word();
        return bus.block_out[W-1:0];
    endfunction

    int bc;
    int b0;

    initial begin
        rst = 1'b1;
        bus.pc_in = 32'h0;
        bus.mem_valid = 1'b0;
        #12;
        check("rst_hit", 64'(bus.hit), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_block", 64'(|bus.block_out), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk_en = 1'b1;

        // cold miss
        wait_hit("cold_wait", 100, bc);
        check("cold_busy_cycles", 64'(bc), 64'd33);
        check("cold_top", 64'(top_word()), 64'h0);
        check("cold_low", 64'(low_word()), 64'd124);

        // hit after fill, same cycle
        bus.pc_in = 32'h40;
        #1;
        check("hit40_hit", 64'(bus.hit), 64'd1);
        check("hit40_req", 64'(bus.mem_req), 64'd0);
        check("hit40_low", 64'(low_word()), 64'd124);
        step();
        step();

        // conflict on index 0
        bus.pc_in = 32'h400;
        wait_hit("conflict_wait", 100, bc);
        check("conflict_top", 64'(top_word()), 64'h400);
        check("conflict_low", 64'(low_word()), 64'h47C);
        bus.pc_in = 32'h0;
        #1;
        check("conflict_remiss", 64'(bus.hit), 64'd0);
        wait_hit("refill0_wait", 100, bc);

        // stalled memory
        vmode = 3;
        b0 = beats;
        bus.pc_in = 32'h100;
        wait_hit("stall_wait", 200, bc);
        check("stall_beats", 64'(beats - b0), 64'd32);
        check("stall_top", 64'(top_word()), 64'h100);
        check("stall_low", 64'(low_word()), 64'h17C);
        vmode = 1;

        // pc change mid-refill
        bus.pc_in = 32'h800;
        wait_addr("midpc_beat10", 32'h828, 50);
        bus.pc_in = 32'h80;
        wait_hit("midpc_wait", 150, bc);
        check("midpc_low", 64'(low_word()), 64'hFC);
        bus.pc_in = 32'h800;
        #1;
        check("midpc_old_line", 64'(bus.hit), 64'd1);
        check("midpc_old_top", 64'(top_word()), 64'h800);
        step();

        // reset at beat 15
        bus.pc_in = 32'h1000;
        wait_addr("rstmid_beat15", 32'h103C, 50);
        rst = 1'b1;
        #1;
        check("rstmid_req", 64'(bus.mem_req), 64'd0);
        check("rstmid_hit", 64'(bus.hit), 64'd0);
        check("rstmid_busy", 64'(bus.busy), 64'd0);
        check("rstmid_addr", 64'(bus.mem_addr), 64'd0);
        bus.pc_in = 32'h0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rstmid_line0_invalid", 64'(bus.hit), 64'd0);
        step();
        #2;
        check("rstmid_restart_req", 64'(bus.mem_req), 64'd1);
        check("rstmid_restart_addr", 64'(bus.mem_addr), 64'd0);
        wait_hit("rstmid_wait", 100, bc);
        check("rstmid_low", 64'(low_word()), 64'd124);

`ifdef ICACHE_STATS_EN
        chk_en = 1'b0;
        rst = 1'b1;
        bus.pc_in = 32'h0;
        #1;
        check("stats_rst_hits", 64'(bus.hit_count), 64'd0);
        check("stats_rst_miss", 64'(bus.miss_count), 64'd0);
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        wait_hit("stats_wait", 100, bc);
        step();
        bus.pc_in = 32'h40;
        step();
        step();
        bus.pc_in = 32'h44;
        step();
        #2;
        check("stats_miss", 64'(bus.miss_count), 64'd1);
        check("stats_hits", 64'(bus.hit_count), 64'd3);
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
